bcd_updown_par_cntr: RTL and testbench

- Parametrised synchronous multi-digit BCD counter.
- Generalises the team's single-digit 4-bit BCD synchronous counter to DIGITS decades.
- Adds an up/down direction, a parallel load, a wrap or saturate mode, and a sticky overflow flag.
- Used as a decade timer or event counter. The carry output allows cascading several instances.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit.sv | 36 +++
 rtl/bcd_updown_par_cntr.sv | 75 +++++++
 tb/tb_bcd_updown_par_cntr.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the digit-validity helper used by the multi-digit counter.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load, increment or decrement on en_in, with 9<->0 rollover.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             at_min,
  output logic             bad
);

  assign at_max = (digit == BCD_MAX);
  assign at_min = (digit == BCD_MIN);
  assign bad    = ~is_bcd(load_digit);

  // An invalid load digit becomes 0, so the counter never holds a non-BCD value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bad ? BCD_MIN : load_digit;
    end else if (en_in) begin
      if (up_dn) begin
        digit <= at_max ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= at_min ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_par_cntr.sv
// Multi-decade BCD up/down counter with parallel load, wrap/saturate mode,
// sticky overflow and a cascade carry.
module bcd_updown_par_cntr
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  ovf,
  output logic                  bad_load
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] bad;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] en_in;
  logic              tc;
  logic              sat_hold;
  logic              step_en;

  assign sel      = up_dn ? at_max : at_min;
  assign tc       = &sel;
  assign carry    = cnt_en & ~load & tc;
  assign sat_hold = !WRAP && tc;
  assign step_en  = cnt_en & ~load & ~sat_hold;

  // Each decade steps only when every lower decade sits at its rollover value.
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_first
        assign en_in[i] = step_en;
      end else begin : g_rest
        assign en_in[i] = en_in[i-1] & sel[i-1];
      end

      bcd_digit u_digit (
        .clk        (clk),
        .rstn       (rstn),
        .en_in      (en_in[i]),
        .up_dn      (up_dn),
        .load       (load),
        .load_digit (load_val[4*i +: 4]),
        .digit      (count[4*i +: 4]),
        .at_max     (at_max[i]),
        .at_min     (at_min[i]),
        .bad        (bad[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf      <= 1'b0;
      bad_load <= 1'b0;
    end else begin
      bad_load <= load & (|bad);
      if (load) begin
        ovf <= 1'b0;
      end else if (carry) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_par_cntr.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// decimal-arithmetic model, on 4-digit wrap, 4-digit saturate and 1-digit counters.
module tb_bcd_updown_par_cntr;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cnt_en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;

  logic [15:0] count_w, count_s;
  logic [3:0]  count_1;
  logic        carry_w, carry_s, carry_1;
  logic        ovf_w, ovf_s, ovf_1;
  logic        bad_w, bad_s, bad_1;

  int total = 0;
  int n_bad = 0;

  int   mval   [3];
  logic movf   [3];
  logic mbad   [3];
  int   ndig   [3] = '{4, 4, 1};
  logic mwrap  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  bcd_updown_par_cntr #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rstn(rstn), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count_w), .carry(carry_w), .ovf(ovf_w), .bad_load(bad_w)
  );

  bcd_updown_par_cntr #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .rstn(rstn), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count_s), .carry(carry_s), .ovf(ovf_s), .bad_load(bad_s)
  );

  bcd_updown_par_cntr #(.DIGITS(1), .WRAP(1'b1)) u_one (
    .clk(clk), .rstn(rstn), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[3:0]), .count(count_1), .carry(carry_1), .ovf(ovf_1), .bad_load(bad_1)
  );

  function automatic int pow10(input int n);
    int r = 1;
    for (int j = 0; j < n; j++) r = r * 10;
    return r;
  endfunction

  function automatic int load_dec(input logic [15:0] lv, input int n);
    int r = 0;
    for (int j = 0; j < n; j++) begin
      int d = int'(lv[4*j +: 4]);
      if (d > 9) d = 0;
      r = r + d * pow10(j);
    end
    return r;
  endfunction

  function automatic logic load_has_bad(input logic [15:0] lv, input int n);
    logic b = 1'b0;
    for (int j = 0; j < n; j++) if (lv[4*j +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int n);
    logic [15:0] r = '0;
    int t = v;
    for (int j = 0; j < n; j++) begin
      r[4*j +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic exp_carry(input int k);
    logic at_tc = up_dn ? (mval[k] == pow10(ndig[k]) - 1) : (mval[k] == 0);
    return cnt_en & ~load & at_tc;
  endfunction

  function automatic logic [15:0] dut_count(input int k);
    if (k == 0) return count_w;
    if (k == 1) return count_s;
    return {12'h000, count_1};
  endfunction

  function automatic logic [2:0] dut_flags(input int k);
    if (k == 0) return {carry_w, ovf_w, bad_w};
    if (k == 1) return {carry_s, ovf_s, bad_s};
    return {carry_1, ovf_1, bad_1};
  endfunction

  task automatic drive(input logic r, input logic en, input logic ud,
                       input logic ld, input logic [15:0] lv);
    rstn = r; cnt_en = en; up_dn = ud; load = ld; load_val = lv;
    #1;
  endtask

  // Advance one edge; the model uses the inputs that were stable at that edge.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int maxv = pow10(ndig[k]) - 1;
      if (!rstn) begin
        mval[k] = 0; movf[k] = 1'b0; mbad[k] = 1'b0;
      end else begin
        mbad[k] = 1'b0;
        if (load) begin
          mval[k] = load_dec(load_val, ndig[k]);
          mbad[k] = load_has_bad(load_val, ndig[k]);
          movf[k] = 1'b0;
        end else if (cnt_en) begin
          if (up_dn) begin
            if (mval[k] == maxv) begin
              movf[k] = 1'b1;
              mval[k] = mwrap[k] ? 0 : maxv;
            end else mval[k] = mval[k] + 1;
          end else begin
            if (mval[k] == 0) begin
              movf[k] = 1'b1;
              mval[k] = mwrap[k] ? maxv : 0;
            end else mval[k] = mval[k] - 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    step(); step();
    total++; if (count_w !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_count got=%h exp=0000", count_w); end
    total++; if (ovf_w !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_w); end
    total++; if (bad_w !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_bad_load got=%b exp=0", bad_w); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int j = 0; j < 12; j++) step();
    total++; if (count_w !== 16'h0012) begin n_bad++; $display("[TB] FAIL up12_count got=%h exp=0012", count_w); end
    total++; if (carry_w !== 1'b0) begin n_bad++; $display("[TB] FAIL up12_carry got=%b exp=0", carry_w); end
    total++; if (ovf_w !== 1'b0) begin n_bad++; $display("[TB] FAIL up12_ovf got=%b exp=0", ovf_w); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0999); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); step();
    total++; if (count_w !== 16'h1000) begin n_bad++; $display("[TB] FAIL cascade_up got=%h exp=1000", count_w); end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h9998); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); step();
    total++; if (count_w !== 16'h9999) begin n_bad++; $display("[TB] FAIL to_9999 got=%h exp=9999", count_w); end
    total++; if (carry_w !== 1'b1) begin n_bad++; $display("[TB] FAIL carry_9999 got=%b exp=1", carry_w); end
    step();
    total++; if (count_w !== 16'h0000) begin n_bad++; $display("[TB] FAIL wrap_zero got=%h exp=0000", count_w); end
    total++; if (ovf_w !== 1'b1) begin n_bad++; $display("[TB] FAIL wrap_ovf got=%b exp=1", ovf_w); end
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0001); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); step();
    total++; if (count_s !== 16'h0000) begin n_bad++; $display("[TB] FAIL sat_down got=%h exp=0000", count_s); end
    total++; if (carry_s !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_carry got=%b exp=1", carry_s); end
    step(); step(); step();
    total++; if (count_s !== 16'h0000) begin n_bad++; $display("[TB] FAIL sat_hold got=%h exp=0000", count_s); end
    total++; if (ovf_s !== 1'b1) begin n_bad++; $display("[TB] FAIL sat_ovf got=%b exp=1", ovf_s); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    total++; if (carry_s !== 1'b0) begin n_bad++; $display("[TB] FAIL dir_carry got=%b exp=0", carry_s); end
    step();
    total++; if (count_s !== 16'h0001) begin n_bad++; $display("[TB] FAIL dir_up got=%h exp=0001", count_s); end
    total++; if (ovf_s !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_sticky got=%b exp=1", ovf_s); end
  endtask

  task automatic test_bad_load();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h1A3F); step();
    total++; if (count_w !== 16'h1030) begin n_bad++; $display("[TB] FAIL bad_load_count got=%h exp=1030", count_w); end
    total++; if (bad_w !== 1'b1) begin n_bad++; $display("[TB] FAIL bad_load_pulse got=%b exp=1", bad_w); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); step();
    total++; if (bad_w !== 1'b0) begin n_bad++; $display("[TB] FAIL bad_load_clear got=%b exp=0", bad_w); end
    total++; if (count_w !== 16'h1030) begin n_bad++; $display("[TB] FAIL hold_count got=%h exp=1030", count_w); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h4567); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); step(); step(); step();
    total++; if (count_w !== 16'h4570) begin n_bad++; $display("[TB] FAIL mid_count got=%h exp=4570", count_w); end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF); step();
    total++; if (count_w !== 16'h0000) begin n_bad++; $display("[TB] FAIL mid_reset_count got=%h exp=0000", count_w); end
    total++; if ({ovf_w, bad_w} !== 2'b00) begin n_bad++; $display("[TB] FAIL mid_reset_flags got=%b exp=00", {ovf_w, bad_w}); end
  endtask

  task automatic test_enable();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h9999); step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    total++; if (carry_w !== 1'b0) begin n_bad++; $display("[TB] FAIL gated_carry got=%b exp=0", carry_w); end
    step();
    total++; if (count_w !== 16'h9999) begin n_bad++; $display("[TB] FAIL gated_hold got=%h exp=9999", count_w); end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0008); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000); step();
    total++; if (count_1 !== 4'd9) begin n_bad++; $display("[TB] FAIL one_digit_9 got=%h exp=9", count_1); end
    total++; if (carry_1 !== 1'b1) begin n_bad++; $display("[TB] FAIL one_digit_carry got=%b exp=1", carry_1); end
    step();
    total++; if (count_1 !== 4'd0) begin n_bad++; $display("[TB] FAIL one_digit_wrap got=%h exp=0", count_1); end
  endtask

  // Random traffic biased toward terminal counts and invalid load digits.
  task automatic test_random();
    logic ud = 1'b1;
    logic [15:0] lv;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) ud = ~ud;
      case ($urandom_range(0, 3))
        0: lv = 16'($urandom);
        1: lv = 16'h9998;
        2: lv = 16'h0001;
        default: lv = to_bcd(int'($urandom_range(0, 9999)), 4);
      endcase
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), ud,
            ($urandom_range(0, 11) == 0), lv);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (dut_flags(k)[2] !== exp_carry(k)) begin
          n_bad++; $display("[TB] FAIL rand_carry dut=%0d got=%b exp=%b", k, dut_flags(k)[2], exp_carry(k));
        end
      end
      step();
      for (int k = 0; k < 3; k++) begin
        total++;
        if (dut_count(k) !== to_bcd(mval[k], ndig[k])) begin
          n_bad++; $display("[TB] FAIL rand_count dut=%0d got=%h exp=%h", k, dut_count(k), to_bcd(mval[k], ndig[k]));
        end
        total++;
        if (dut_flags(k)[1:0] !== {movf[k], mbad[k]}) begin
          n_bad++; $display("[TB] FAIL rand_flags dut=%0d got=%b exp=%b", k, dut_flags(k)[1:0], {movf[k], mbad[k]});
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin mval[k] = 0; movf[k] = 1'b0; mbad[k] = 1'b0; end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    $display("[TB] starting");
    test_reset();
    test_wrap();
    test_saturate();
    test_bad_load();
    test_reset_mid();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
